// File: rtl/ewb_multi_if.sv
// Bus bundle for the multi-entry eviction write buffer: the L2-side request
// channel and the memory-side request channel. The buffer uses the slave
// view; the L2 cache / memory model side uses the master view.
interface ewb_multi_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              ewb_read_i;
  logic              ewb_write_i;
  logic [ADDR_W-1:0] ewb_addr_i;
  logic [LINE_W-1:0] ewb_wdata_i;
  logic [LINE_W-1:0] ewb_rdata_o;
  logic              ewb_resp_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic [LINE_W-1:0] mem_rdata_i;
  logic              mem_resp_i;

  modport slave (
    input  ewb_read_i, ewb_write_i, ewb_addr_i, ewb_wdata_i,
    input  mem_rdata_i, mem_resp_i,
    output ewb_rdata_o, ewb_resp_o,
    output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output ewb_read_i, ewb_write_i, ewb_addr_i, ewb_wdata_i,
    output mem_rdata_i, mem_resp_i,
    input  ewb_rdata_o, ewb_resp_o,
    input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/ewb_multi.sv
// Multi-entry eviction write buffer. Dirty lines evicted from L2 are queued
// in a circular FIFO and written to memory in arrival order. Reads hit any
// buffered entry in one cycle, writes to a buffered address coalesce in
// place, and read misses go to memory ahead of any pending drain.
module ewb_multi #(
  parameter int DEPTH        = 4,
  parameter int LINE_W       = 256,
  parameter int ADDR_W       = 32,
  parameter int DRAIN_THRESH = 1,
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  ewb_multi_if.slave       bus,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_DRAIN     = 2'd1;
  localparam logic [1:0] S_READ_MISS = 2'd2;

  logic [1:0]        r_state;
  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [LINE_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_miss_addr;

  logic              w_hit;
  logic [PTR_W-1:0]  w_hit_idx;
  logic              w_in_drain;
  logic              w_in_miss;
  logic              w_full;
  logic              w_head_block;
  logic              w_wr_merge;
  logic              w_wr_alloc;
  logic              w_rd_hit;
  logic              w_rd_fill;
  logic              w_rd_miss_idle;
  logic              w_pop;

  // Associative lookup of the request address; coalescing keeps hits unique.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == bus.ewb_addr_i)) begin
        w_hit     = 1'b1;
        w_hit_idx = PTR_W'(i);
      end
    end
  end

  // Request decode: the head entry is frozen while it is on the memory bus.
  always_comb begin
    w_in_drain     = (r_state == S_DRAIN);
    w_in_miss      = (r_state == S_READ_MISS);
    w_full         = (r_count == CNT_W'(DEPTH));
    w_head_block   = w_in_drain && w_hit && (w_hit_idx == r_head);
    w_wr_merge     = bus.ewb_write_i && w_hit && !w_head_block;
    w_wr_alloc     = bus.ewb_write_i && !w_hit && !w_full;
    w_rd_hit       = bus.ewb_read_i && w_hit;
    w_rd_fill      = bus.ewb_read_i && w_in_miss && bus.mem_resp_i;
    w_rd_miss_idle = bus.ewb_read_i && !w_hit && (r_state == S_IDLE);
    w_pop          = w_in_drain && bus.mem_resp_i;
  end

  // Outputs; reset silences every request and response in the same cycle.
  always_comb begin
    bus.ewb_resp_o  = !rst && (w_wr_merge || w_wr_alloc || w_rd_hit || w_rd_fill);
    bus.ewb_rdata_o = '0;
    if (!rst && w_rd_hit)
      bus.ewb_rdata_o = r_data[w_hit_idx];
    else if (!rst && w_rd_fill)
      bus.ewb_rdata_o = bus.mem_rdata_i;
    bus.mem_read_o  = !rst && w_in_miss;
    bus.mem_write_o = !rst && w_in_drain;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (!rst && w_in_miss) begin
      bus.mem_addr_o = r_miss_addr;
    end else if (!rst && w_in_drain) begin
      bus.mem_addr_o  = r_addr[r_head];
      bus.mem_wdata_o = r_data[r_head];
    end
    count_o = rst ? '0 : r_count;
    full_o  = !rst && w_full;
    empty_o = rst || (r_count == '0);
  end

  // Control state: FIFO pointers, valid bits, occupancy and arbitration FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_wr_alloc) - CNT_W'(w_pop);
      case (r_state)
        S_IDLE: begin
          if (w_rd_miss_idle)
            r_state <= S_READ_MISS;
          else if (r_count >= CNT_W'(DRAIN_THRESH))
            r_state <= S_DRAIN;
        end
        S_DRAIN:     if (bus.mem_resp_i) r_state <= S_IDLE;
        S_READ_MISS: if (bus.mem_resp_i) r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  // Line storage and latched miss address; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (w_wr_alloc) begin
      r_addr[r_tail] <= bus.ewb_addr_i;
      r_data[r_tail] <= bus.ewb_wdata_i;
    end else if (w_wr_merge) begin
      r_data[w_hit_idx] <= bus.ewb_wdata_i;
    end
    if (w_rd_miss_idle)
      r_miss_addr <= bus.ewb_addr_i;
  end

endmodule

// File: tb/tb_ewb_multi.sv
// Bench for ewb_multi: directed L2 requests with a scoreboard of expected
// responses, a memory model that checks drained lines and miss addresses,
// and a monitor that pops expectations whenever the buffer responds.
`timescale 1ns/1ps
module tb_ewb_multi;
  localparam int DEPTH  = 4;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam int THR    = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] count_o;
  logic             full_o;
  logic             empty_o;

  ewb_multi_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

  ewb_multi #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .DRAIN_THRESH(THR)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [LINE_W-1:0] q_resp[$];
  logic [ADDR_W-1:0] q_rdaddr[$];
  logic [ADDR_W-1:0] q_dr_addr[$];
  logic [LINE_W-1:0] q_dr_data[$];

  int mem_lat        = 0;
  bit mem_hold       = 1'b1;
  int last_mresp_cyc = -10;

  function automatic logic [LINE_W-1:0] mfn(input logic [ADDR_W-1:0] a);
    return {8{a ^ 32'hA5A5_0000}};
  endfunction

  function automatic logic [LINE_W-1:0] dv(input int k);
    return {8{32'hD000_0000 + 32'(k)}};
  endfunction

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got none want one", nm);
  endtask

  // L2-side response monitor.
  always @(negedge clk) begin
    if (!rst) begin
      chk("mem_rd_wr_exclusive", LINE_W'(bus.mem_read_o & bus.mem_write_o), '0);
      if (bus.ewb_resp_o) begin
        if (q_resp.size() == 0) miss("expected_resp_entry");
        else chk("ewb_rdata", bus.ewb_rdata_o, q_resp.pop_front());
      end
    end
  end

  // Memory model: responds mem_lat cycles after a request unless held.
  initial begin
    int wc;
    wc = 0;
    bus.mem_resp_i  = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (rst || !(bus.mem_read_o || bus.mem_write_o) || mem_hold) begin
        wc = 0;
      end else if (wc < mem_lat) begin
        wc++;
      end else begin
        wc = 0;
        if (bus.mem_write_o) begin
          if (q_dr_addr.size() == 0) miss("expected_drain_entry");
          else begin
            chk("drain_addr", LINE_W'(bus.mem_addr_o), LINE_W'(q_dr_addr.pop_front()));
            chk("drain_data", bus.mem_wdata_o, q_dr_data.pop_front());
          end
        end else begin
          if (q_rdaddr.size() == 0) miss("expected_miss_entry");
          else chk("miss_addr", LINE_W'(bus.mem_addr_o), LINE_W'(q_rdaddr.pop_front()));
        end
        @(posedge clk); #1;
        bus.mem_resp_i  = 1'b1;
        bus.mem_rdata_i = bus.mem_read_o ? mfn(bus.mem_addr_o) : '0;
        last_mresp_cyc  = cyc;
        @(posedge clk); #1;
        bus.mem_resp_i  = 1'b0;
        bus.mem_rdata_i = '0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(input bit wr, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                     input logic [LINE_W-1:0] exp_rd, output int acc);
    int n;
    q_resp.push_back(wr ? '0 : exp_rd);
    bus.ewb_write_i = wr;
    bus.ewb_read_i  = !wr;
    bus.ewb_addr_i  = a;
    bus.ewb_wdata_i = wr ? d : '0;
    n   = 0;
    acc = -1;
    while (acc < 0 && n < 300) begin
      @(negedge clk);
      if (bus.ewb_resp_o) acc = cyc;
      n++;
    end
    if (acc < 0) begin
      miss("req_resp_timeout");
      void'(q_resp.pop_back());
    end
    @(posedge clk); #1;
    bus.ewb_write_i = 1'b0;
    bus.ewb_read_i  = 1'b0;
  endtask

  task automatic stall_write(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d, input string nm);
    int acc;
    fork
      req(1'b1, a, d, '0, acc);
      begin
        repeat (3) begin
          @(negedge clk);
          chk({nm, "_noresp"}, LINE_W'(bus.ewb_resp_o), '0);
        end
        mem_lat  = 0;
        mem_hold = 1'b0;
      end
    join
    mem_hold = 1'b1;
    chk({nm, "_accept_cycle"}, LINE_W'(acc), LINE_W'(last_mresp_cyc + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n;
    rst = 1'b1;
    bus.ewb_read_i  = 1'b0;
    bus.ewb_write_i = 1'b0;
    bus.ewb_addr_i  = '0;
    bus.ewb_wdata_i = '0;

    // reset values
    @(negedge clk);
    chk("rst_count", LINE_W'(count_o), '0);
    chk("rst_empty", LINE_W'(empty_o), LINE_W'(1));
    chk("rst_full", LINE_W'(full_o), '0);
    chk("rst_memwr", LINE_W'(bus.mem_write_o | bus.mem_read_o), '0);
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("post_rst_empty", LINE_W'(empty_o), LINE_W'(1));

    // single write, below drain threshold
    req(1'b1, 32'h100, dv(0), '0, acc);
    chk("a_count", LINE_W'(count_o), LINE_W'(1));
    chk("a_empty", LINE_W'(empty_o), '0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("a_no_drain", LINE_W'(bus.mem_write_o), '0);
    end

    // read miss goes to memory and returns its data in the response cycle
    q_rdaddr.push_back(32'h300);
    mem_lat  = 3;
    mem_hold = 1'b0;
    req(1'b0, 32'h300, '0, mfn(32'h300), acc);
    mem_hold = 1'b1;
    chk("b_miss_same_cycle", LINE_W'(acc), LINE_W'(last_mresp_cyc));
    chk("b_count", LINE_W'(count_o), LINE_W'(1));

    // second write crosses the threshold; drain of the oldest entry starts
    q_dr_addr.push_back(32'h100); q_dr_data.push_back(dv(0));
    req(1'b1, 32'h140, dv(1), '0, acc);
    tick(3);
    chk("c_memwr", LINE_W'(bus.mem_write_o), LINE_W'(1));
    chk("c_memaddr", LINE_W'(bus.mem_addr_o), LINE_W'(32'h100));
    chk("c_memwdata", bus.mem_wdata_o, dv(0));
    chk("c_count", LINE_W'(count_o), LINE_W'(2));

    // coalesce into a non-head entry, read hits including the draining head
    req(1'b1, 32'h140, dv(2), '0, acc);
    tick(1);
    chk("d_count_coalesce", LINE_W'(count_o), LINE_W'(2));
    req(1'b0, 32'h140, '0, dv(2), acc);
    req(1'b0, 32'h100, '0, dv(0), acc);
    q_dr_addr.push_back(32'h140); q_dr_data.push_back(dv(2));
    stall_write(32'h100, dv(3), "d_head_stall");
    q_dr_addr.push_back(32'h100); q_dr_data.push_back(dv(3));
    tick(1);
    chk("d_count_after", LINE_W'(count_o), LINE_W'(2));

    // fill to full, then a fifth write waits for the first pop
    req(1'b1, 32'h180, dv(4), '0, acc);
    q_dr_addr.push_back(32'h180); q_dr_data.push_back(dv(4));
    req(1'b1, 32'h1C0, dv(5), '0, acc);
    q_dr_addr.push_back(32'h1C0); q_dr_data.push_back(dv(5));
    chk("e_count_full", LINE_W'(count_o), LINE_W'(4));
    chk("e_full", LINE_W'(full_o), LINE_W'(1));
    stall_write(32'h200, dv(6), "e_full_stall");
    q_dr_addr.push_back(32'h200); q_dr_data.push_back(dv(6));
    chk("e_count_refill", LINE_W'(count_o), LINE_W'(4));
    chk("e_full_again", LINE_W'(full_o), LINE_W'(1));

    // drain in arrival order until occupancy falls below the threshold
    mem_lat  = 2;
    mem_hold = 1'b0;
    n = 0;
    while (!(count_o == CNT_W'(1) && !bus.mem_write_o) && n < 300) begin
      @(negedge clk);
      n++;
    end
    mem_hold = 1'b1;
    chk("e_drain_done", LINE_W'(n < 300), LINE_W'(1));
    tick(2);
    chk("e_count_left", LINE_W'(count_o), LINE_W'(1));
    chk("e_left_queue", LINE_W'(q_dr_addr.size()), LINE_W'(1));
    chk("e_not_full", LINE_W'(full_o), '0);

    // reset in the middle of a drain abandons it
    req(1'b1, 32'h240, dv(7), '0, acc);
    tick(3);
    chk("f_memwr", LINE_W'(bus.mem_write_o), LINE_W'(1));
    chk("f_memaddr", LINE_W'(bus.mem_addr_o), LINE_W'(32'h200));
    rst = 1'b1;
    @(negedge clk);
    chk("f_rst_memwr", LINE_W'(bus.mem_write_o), '0);
    chk("f_rst_count", LINE_W'(count_o), '0);
    chk("f_rst_empty", LINE_W'(empty_o), LINE_W'(1));
    tick(1);
    rst = 1'b0;
    q_dr_addr.delete();
    q_dr_data.delete();
    tick(1);
    chk("f_post_memwr", LINE_W'(bus.mem_write_o), '0);
    chk("f_post_count", LINE_W'(count_o), '0);
    chk("f_post_empty", LINE_W'(empty_o), LINE_W'(1));
    q_rdaddr.push_back(32'h200);
    mem_lat  = 1;
    mem_hold = 1'b0;
    req(1'b0, 32'h200, '0, mfn(32'h200), acc);
    mem_hold = 1'b1;
    chk("f_read_missed", LINE_W'(acc), LINE_W'(last_mresp_cyc));

    tick(5);
    chk("end_resp_queue", LINE_W'(q_resp.size()), '0);
    chk("end_miss_queue", LINE_W'(q_rdaddr.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ewb_multi.md
Name: ewb_multi

Overview:
- Parametrised multi-entry eviction write buffer between the L2 cache (lower-level port) and the memory/arbiter side (higher-level port).
- Holds up to DEPTH dirty evicted lines in a circular FIFO and drains them to memory in arrival order.
- Serves read hits from any buffered entry in one cycle and coalesces writes to an already-buffered address.
- Read misses pass through to memory with priority over draining. Successor to the single-entry write buffer.

Parameters:
- DEPTH, 4, number of line entries; power of two, >=2.
- LINE_W, 256, line data width in bits.
- ADDR_W, 32, line address width in bits (line-aligned).
- DRAIN_THRESH, 1, minimum occupancy that starts a drain, 1..DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ewb_read_i  in  1  lower-level read request; held until ewb_resp_o.
- ewb_write_i  in  1  lower-level write request; held until ewb_resp_o; never asserted together with ewb_read_i.
- ewb_addr_i  in  ADDR_W  request address.
- ewb_wdata_i  in  LINE_W  write line.
- ewb_rdata_o  out  LINE_W  read data, valid when ewb_resp_o is high on a read.
- ewb_resp_o  out  1  single-cycle completion pulse.
- mem_read_o  out  1  memory read request.
- mem_write_o  out  1  memory write request.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  LINE_W  memory write data.
- mem_rdata_i  in  LINE_W  memory read data.
- mem_resp_i  in  1  memory completion pulse.
- count_o  out  $clog2(DEPTH+1)  occupied entries.
- full_o  out  1  count_o == DEPTH.
- empty_o  out  1  count_o == 0.

Behaviour:
- Storage:
  - Per-entry valid bit, address, data.
  - head/tail pointers of width $clog2(DEPTH), wrapping modulo DEPTH.
  - count_o is registered; it increments on allocate and decrements on pop, and both in one cycle leave it unchanged.
- Match: combinational compare of ewb_addr_i against all valid entries. Coalescing guarantees at most one match.
- Reset: all valid bits 0, head = tail = 0, count 0, state IDLE. All outputs 0 except empty_o = 1. Reset mid-drain or mid-miss abandons the transaction and drops mem_* requests the same cycle.
- States: IDLE, DRAIN, READ_MISS.
- Write handling (evaluated in every state):
  - Match on a non-head, or on the head when not in DRAIN: overwrite that entry's data, ewb_resp_o = 1 the same cycle, count unchanged.
  - Match on the head entry while in DRAIN: stall. After the pop the address no longer matches and the write allocates.
  - No match and count < DEPTH: write to the tail, set valid, tail+1, ewb_resp_o the same cycle.
  - No match and full: stall with no resp. This includes the cycle in which mem_resp_i pops; the write is accepted the following cycle.
- Read hit (any state): ewb_rdata_o = matching entry's data, ewb_resp_o the same cycle. The head being drained is still readable.
- IDLE:
  - Read miss: latch the address and go to READ_MISS. Read misses take priority over drain.
  - Otherwise, if count_o >= DRAIN_THRESH, go to DRAIN.
- READ_MISS:
  - mem_read_o = 1 and mem_addr_o = latched address, held stable until the response.
  - On mem_resp_i: ewb_rdata_o = mem_rdata_i and ewb_resp_o = 1 the same cycle, then go to IDLE.
- DRAIN:
  - mem_write_o = 1, with mem_addr_o/mem_wdata_o = head entry, held stable until the response.
  - A read miss arriving here waits for drain completion.
  - On mem_resp_i: clear head valid, head+1, then go to IDLE. IDLE re-arbitrates next cycle, so back-to-back drains have one idle cycle between them.
- mem_read_o and mem_write_o are never high together.
- ewb_rdata_o = 0 when not responding to a read.

Test Plan:
- Reset, then write A=0x100 with data D0 -> ewb_resp_o in the same cycle, count_o=1, next cycle DRAIN with mem_write_o=1 and mem_addr_o=0x100; mem_resp_i after 5 cycles -> count_o=0, empty_o=1.
- DRAIN_THRESH=4, write 0x100, 0x140, 0x180 -> no mem_write_o; fourth write 0x1C0 -> full_o=1, then drains in order 0x100, 0x140, 0x180, 0x1C0.
- DRAIN_THRESH=4, buffer {0x100:D0, 0x140:D1}, write 0x140 with D2 -> resp, count stays 2; read 0x140 -> ewb_rdata_o=D2 in one cycle.
- Buffer full, fifth write 0x200 -> no resp until the cycle after the first mem_resp_i, then resp, with tail wrapped to index 0.
- Buffer holding 0x100 with DRAIN_THRESH=2, read 0x300 -> mem_read_o=1 and mem_addr_o=0x300; mem_rdata_i=R on resp -> ewb_rdata_o=R and ewb_resp_o together, no mem_write_o during the miss.
- Assert rst mid-DRAIN -> next cycle mem_write_o=0, count_o=0, empty_o=1, and read 0x100 misses.
